alu_issue_ctrl: RTL and testbench

Sequential command issuer that drives the 8-bit combinational ALU from the initiator side. It accepts operand/opcode commands over a valid/ready handshake and drives them onto the ALU's `A`/`B`/`op` inputs. It samples the ALU result and returns it with a valid/ready response handshake and an illegal-opcode flag. The block sits between the datapath controller and the ALU and keeps completion and error counts.

---
 rtl/alu_issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Command issuer for the 8-bit combinational ALU: valid/ready command in, registered ALU drive,
// captured result out with an illegal-opcode flag. Define ALU_ISSUE_CHECK_EN to build the result checker.
module alu_issue_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_op,
    output logic             rsp_err,
    output logic             rsp_mismatch,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'b1000;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_op_q, rsp_op_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             mismatch_now;

`ifdef ALU_ISSUE_CHECK_EN
    logic             rsp_mismatch_q, rsp_mismatch_d;

    // Golden opcode map; shifts by B >= WIDTH fall out as zero from the shift operators.
    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [3:0]       op);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            4'b0000:          r = a + b;
            4'b0001:          r = a - b;
            4'b0010, 4'b0101: r = a << b;
            4'b0011, 4'b0100: r = a >> b;
            4'b0110:          r = a | b;
            4'b0111:          r = a ^ b;
            4'b1000:          r = a & b;
            default:          r = '0;
        endcase
        return r;
    endfunction

    assign mismatch_now = (alu_out != ref_alu(alu_a_q, alu_b_q, alu_op_q));
`else
    assign mismatch_now = 1'b0;
`endif

    // NOTE: every always_comb target starts from its held value so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        done_cnt_d  = done_cnt_q;
        err_cnt_d   = err_cnt_q;
`ifdef ALU_ISSUE_CHECK_EN
        rsp_mismatch_d = rsp_mismatch_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // ALU inputs have been stable for a full cycle; its output is settled here.
                rsp_data_d  = alu_out;
                rsp_op_d    = alu_op_q;
                rsp_err_d   = (alu_op_q > OP_LAST_LEGAL);
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
`ifdef ALU_ISSUE_CHECK_EN
                rsp_mismatch_d = mismatch_now;
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    done_cnt_d  = done_cnt_q + 1'b1;
                    err_cnt_d   = err_cnt_q + CNT_W'(rsp_err_q);
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef ALU_ISSUE_CHECK_EN
                    rsp_mismatch_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
            done_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
            done_cnt_q  <= done_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

`ifdef ALU_ISSUE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) rsp_mismatch_q <= 1'b0;
        else        rsp_mismatch_q <= rsp_mismatch_d;
    end
    assign rsp_mismatch = rsp_mismatch_q;
`else
    assign rsp_mismatch = mismatch_now;
`endif

    // Readiness depends on registered state only, never on rsp_ready.
    assign cmd_ready = (state_q == S_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_err   = rsp_err_q;
    assign done_cnt  = done_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU stub plus a transaction-level reference
// (expected result per opcode map, response counters) driven by directed and random commands.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
`ifdef ALU_ISSUE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_op;
    logic             rsp_err, rsp_mismatch;
    logic [CNT_W-1:0] done_cnt, err_cnt;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    bit               force_zero = 1'b0;
    logic [CNT_W-1:0] m_done = '0;
    logic [CNT_W-1:0] m_err  = '0;

    alu_issue_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .rsp_mismatch(rsp_mismatch), .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Opcode map evaluated with integer arithmetic, then truncated to WIDTH.
    function automatic logic [WIDTH-1:0] model_alu(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b + 256;
            2, 5:    r = (b >= WIDTH) ? 0 : a * (1 << b);
            3, 4:    r = (b >= WIDTH) ? 0 : a / (1 << b);
            6:       r = a | b;
            7:       r = a ^ b;
            8:       r = a & b;
            default: r = 0;
        endcase
        return WIDTH'(r % 256);
    endfunction

    always_comb alu_out = force_zero ? '0 : model_alu(int'(alu_a), int'(alu_b), int'(alu_op));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One full transaction; hold = cycles of rsp_ready low in RESP, keep_valid drives junk while busy.
    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input int hold, input bit keep_valid, output int acc_cyc);
        logic [7:0] good, exp_d;
        bit         exp_e, exp_m;
        good  = model_alu(int'(a), int'(b), int'(op));
        exp_d = force_zero ? 8'h00 : good;
        exp_m = CHK && (exp_d != good);
        exp_e = (op > 4'd8);

        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (keep_valid) begin
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 4'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("alu_op", alu_op, op);
        check("drive_cmd_ready", cmd_ready, 0);
        check("drive_rsp_valid", rsp_valid, 0);

        @(posedge clk); #1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_d);
        check("rsp_op", rsp_op, op);
        check("rsp_err", rsp_err, exp_e);
        check("rsp_mismatch", rsp_mismatch, exp_m);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, exp_d);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_alu_a", alu_a, a);
            check("bp_alu_b", alu_b, b);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        m_done++;
        if (exp_e) m_err++;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
        check("post_alu_op_hold", alu_op, op);
        check("done_cnt", done_cnt, m_done);
        check("err_cnt", err_cnt, m_err);
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_op"}, alu_op, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_op"}, rsp_op, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_rsp_mismatch"}, rsp_mismatch, 0);
        check({tag, "_done_cnt"}, done_cnt, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    // Issue a command then assert reset while it is in DRIVE (in_resp=0) or RESP (in_resp=1).
    task automatic reset_mid(input bit in_resp);
        cmd_a = 8'h5A; cmd_b = 8'h3C; cmd_op = 4'b1010; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (in_resp) begin
            @(posedge clk); #1;
            check("pre_reset_rsp_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b0;
        m_done = '0;
        m_err  = '0;
        check_reset_state(in_resp ? "rst_resp" : "rst_drive");
    endtask

    initial begin
        int acc, prev;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        do_cmd(8'hF0, 8'h20, 4'b0000, 0, 1'b0, acc);

        // Back-to-back sub and shifts; acceptances must be 3 cycles apart.
        do_cmd(8'h05, 8'h07, 4'b0001, 0, 1'b0, prev);
        do_cmd(8'h81, 8'h01, 4'b0010, 0, 1'b0, acc);
        check("throughput_1", acc - prev, 3);
        prev = acc;
        do_cmd(8'h81, 8'h01, 4'b0011, 0, 1'b0, acc);
        check("throughput_2", acc - prev, 3);
        prev = acc;
        do_cmd(8'h81, 8'h08, 4'b0101, 0, 1'b0, acc);
        check("throughput_3", acc - prev, 3);

        do_cmd(8'hFF, 8'hFF, 4'b1010, 0, 1'b0, acc);

        // Backpressure with cmd_valid held high and fresh operands on the bus.
        do_cmd(8'hAA, 8'h0F, 4'b0111, 10, 1'b1, prev);
        do_cmd(8'h12, 8'h34, 4'b0110, 0, 1'b0, acc);
        check("accept_after_bp", acc - prev, 13);

        force_zero = 1'b1;
        do_cmd(8'hF0, 8'h3C, 4'b1000, 1, 1'b0, acc);
        force_zero = 1'b0;
        do_cmd(8'hF0, 8'h3C, 4'b1000, 0, 1'b0, acc);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            logic [3:0] rop;
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            rop = 4'($urandom_range(0, 15));
            do_cmd(ra, rb, rop, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), acc);
            cmd_valid = 1'b0;
        end

        reset_mid(1'b0);
        do_cmd(8'h01, 8'h02, 4'b0000, 0, 1'b0, acc);
        reset_mid(1'b1);
        do_cmd(8'h09, 8'h03, 4'b1011, 0, 1'b0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
